// File: rtl/sd_dma_pkg.sv
// sd_dma_pkg: register map, CTRL bit positions, FSM encoding and SD token constants
package sd_dma_pkg;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_COUNT_LO  = 3'd1;
    localparam logic [2:0] REG_COUNT_HI  = 3'd2;
    localparam logic [2:0] REG_OFFSET_LO = 3'd3;
    localparam logic [2:0] REG_OFFSET_HI = 3'd4;
    localparam logic [2:0] REG_SPIDATA   = 3'd5;
    localparam logic [2:0] REG_SPICS     = 3'd6;
    localparam logic [2:0] REG_TOKLIM    = 3'd7;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_ACK   = 2;
    localparam int CTRL_IEN   = 7;

    localparam logic [7:0] TOK_START = 8'hFE;
    localparam logic [7:0] TOK_IDLE  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_POLL,
        ST_DATA,
        ST_CRC
    } state_t;

    // A zero count field selects the full range
    function automatic logic [9:0] byte_limit(input logic [8:0] n);
        return n == 9'd0 ? 10'd512 : {1'b0, n};
    endfunction

    function automatic logic [8:0] tok_limit(input logic [7:0] n);
        return n == 8'd0 ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// spi_byte_engine: mode-0 MSB-first SPI byte shifter with SCLK divider
module spi_byte_engine #(
    parameter int CLKDIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       abort,
    input  logic       start,
    input  logic [7:0] tx,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx,
    output logic       done
);
    logic       busy, tick;
    logic [7:0] tx_sh, div;
    logic [3:0] half;

    assign tick = busy && div == 8'(CLKDIV - 1);
    assign done = tick && half == 4'd15;
    assign mosi = busy ? tx_sh[7] : 1'b1;

    // A new byte may start in the same clk the previous one finishes
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy  <= 1'b0;
            sclk  <= 1'b0;
            div   <= 8'd0;
            half  <= 4'd0;
            tx_sh <= 8'hFF;
            rx    <= 8'd0;
        end else if (start && (!busy || done)) begin
            busy  <= 1'b1;
            sclk  <= 1'b0;
            div   <= 8'd0;
            half  <= 4'd0;
            tx_sh <= tx;
        end else if (tick) begin
            div  <= 8'd0;
            half <= half + 4'd1;
            sclk <= ~sclk;
            if (!half[0]) rx <= {rx[6:0], miso};
            else tx_sh <= {tx_sh[6:0], 1'b1};
            if (done) busy <= 1'b0;
        end else if (busy) begin
            div <= div + 8'd1;
        end
    end

endmodule

// File: rtl/sd_sector_dma.sv
// sd_sector_dma: CPU-programmed SPI engine that polls for an SD data token and DMAs a sector into a buffer
module sd_sector_dma
    import sd_dma_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] reg_a,
    input  logic [7:0] reg_d_in,
    output logic [7:0] reg_d_out,
    input  logic       reg_cs,
    input  logic       reg_we,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    input  logic       spi_miso,
    output logic [9:0] buf_a,
    output logic [7:0] buf_d,
    output logic       buf_cs,
    output logic       buf_we,
    output logic       irq
);
    state_t     state, state_nx;
    logic       ien, done, terr, kerr, spics, busy;
    logic [8:0] count, offset, cnt_l, off_l, poll, buf_lo;
    logic [7:0] spidata, toklim, eng_tx, eng_rx;
    logic [9:0] idx;
    logic       wr, start, abort, ack, poll_last, data_last;
    logic       eng_start, eng_done, buf_wr, set_done, set_terr, set_kerr, start_ok;

    assign wr        = reg_cs & reg_we;
    assign start     = wr && reg_a == REG_CTRL && reg_d_in[CTRL_START];
    assign abort     = wr && reg_a == REG_CTRL && reg_d_in[CTRL_ABORT];
    assign ack       = wr && reg_a == REG_CTRL && reg_d_in[CTRL_ACK];
    assign poll_last = poll + 9'd1 == tok_limit(toklim);
    assign data_last = idx + 10'd1 == byte_limit(cnt_l);
    assign busy      = state != ST_IDLE;
    assign buf_a     = {1'b1, buf_lo};
    assign buf_cs    = buf_we;
    assign spi_cs_n  = ~spics;
    assign irq       = ien & (done | terr | kerr);

    spi_byte_engine #(.CLKDIV(CLKDIV)) u_eng (
        .clk  (clk),
        .rst  (rst),
        .abort(abort),
        .start(eng_start),
        .tx   (eng_tx),
        .miso (spi_miso),
        .sclk (spi_sclk),
        .mosi (spi_mosi),
        .rx   (eng_rx),
        .done (eng_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) state_nx = ST_IDLE;
        else begin
            case (state)
                ST_IDLE:   state_nx = start ? ST_POLL : (wr && reg_a == REG_SPIDATA) ? ST_MANUAL : ST_IDLE;
                ST_MANUAL: state_nx = eng_done ? ST_IDLE : ST_MANUAL;
                ST_POLL:   state_nx = !eng_done ? ST_POLL : eng_rx == TOK_START ? ST_DATA :
                                      (eng_rx == TOK_IDLE && !poll_last) ? ST_POLL : ST_IDLE;
                ST_DATA:   state_nx = (eng_done && data_last) ? ST_CRC : ST_DATA;
                ST_CRC:    state_nx = (eng_done && idx[0]) ? ST_IDLE : ST_CRC;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Bytes run back to back: the next one starts in the clk the previous one completes
    always_comb begin
        start_ok  = state == ST_IDLE && start && !abort;
        eng_start = !abort && state_nx != ST_IDLE && (state == ST_IDLE || eng_done);
        eng_tx    = state_nx == ST_MANUAL ? reg_d_in : TOK_IDLE;
        buf_wr    = !abort && state == ST_DATA && eng_done;
        set_done  = !abort && state == ST_CRC && eng_done && idx[0];
        set_terr  = !abort && state == ST_POLL && eng_done && eng_rx == TOK_IDLE && poll_last;
        set_kerr  = !abort && state == ST_POLL && eng_done && eng_rx != TOK_IDLE && eng_rx != TOK_START;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ien     <= 1'b0;
            done    <= 1'b0;
            terr    <= 1'b0;
            kerr    <= 1'b0;
            spics   <= 1'b0;
            count   <= 9'd0;
            offset  <= 9'd0;
            cnt_l   <= 9'd0;
            off_l   <= 9'd0;
            poll    <= 9'd0;
            idx     <= 10'd0;
            toklim  <= 8'd0;
            spidata <= 8'd0;
            buf_we  <= 1'b0;
            buf_d   <= 8'd0;
            buf_lo  <= 9'd0;
        end else begin
            if (wr) begin
                case (reg_a)
                    REG_CTRL:      ien         <= reg_d_in[CTRL_IEN];
                    REG_COUNT_LO:  count[7:0]  <= reg_d_in;
                    REG_COUNT_HI:  count[8]    <= reg_d_in[0];
                    REG_OFFSET_LO: offset[7:0] <= reg_d_in;
                    REG_OFFSET_HI: offset[8]   <= reg_d_in[0];
                    REG_SPICS:     spics       <= reg_d_in[0];
                    REG_TOKLIM:    toklim      <= reg_d_in;
                    default:       ;
                endcase
            end
            done <= set_done | (done & ~(ack | start_ok));
            terr <= set_terr | (terr & ~(ack | start_ok));
            kerr <= set_kerr | (kerr & ~(ack | start_ok));
            if (start_ok) begin
                cnt_l <= count;
                off_l <= offset;
                poll  <= 9'd0;
                idx   <= 10'd0;
            end
            if (!abort && state == ST_MANUAL && eng_done) spidata <= eng_rx;
            if (state == ST_POLL && eng_done && state_nx == ST_POLL) poll <= poll + 9'd1;
            if (buf_wr) idx <= data_last ? 10'd0 : idx + 10'd1;
            if (state == ST_CRC && eng_done) idx <= idx + 10'd1;
            buf_we <= buf_wr;
            if (buf_wr) begin
                buf_d  <= eng_rx;
                buf_lo <= off_l + idx[8:0];
            end
        end
    end

    always_comb begin
        reg_d_out = 8'd0;
        case (reg_a)
            REG_CTRL:      reg_d_out = {ien, 3'b000, kerr, terr, done, busy};
            REG_COUNT_LO:  reg_d_out = count[7:0];
            REG_COUNT_HI:  reg_d_out = {7'd0, count[8]};
            REG_OFFSET_LO: reg_d_out = offset[7:0];
            REG_OFFSET_HI: reg_d_out = {7'd0, offset[8]};
            REG_SPIDATA:   reg_d_out = spidata;
            REG_SPICS:     reg_d_out = {7'd0, spics};
            REG_TOKLIM:    reg_d_out = toklim;
            default:       reg_d_out = 8'd0;
        endcase
    end

endmodule
